wb_commit_arbiter: RTL and testbench

- Shares the single integer writeback/commit port between the long-latency execution units: MUL, DIV, CSR and LSU-load by default.
- Selects one completing instruction per cycle using round-robin arbitration.
- Registers the winner, then drives the register-file write and the commit_valid/commit_id pulse that releases the hazard-unit scoreboard entry.
- Sits between the EX units and the regfile/hazard unit.

---
 rtl/wb_commit_arbiter_pkg.sv | 32 +++
 rtl/wb_commit_arbiter_if.sv | 46 ++++
 rtl/wb_commit_arbiter_rr_arbiter.sv | 40 ++++
 rtl/wb_commit_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_commit_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_commit_arbiter_pkg.sv
// rtl/wb_commit_arbiter_pkg.sv - shared types and widths for the integer writeback/commit arbiter
//
// Purpose: requester indices, writeback request record, default widths and
//          the round-robin pointer advance helper.
// Ports:   none (package).
package wb_commit_arbiter_pkg;

  localparam int NUM_WB_REQ         = 4;
  localparam int WB_COMMIT_ID_WIDTH = 3;
  localparam int WB_REG_ADDR_WIDTH  = 5;
  localparam int WB_DATA_WIDTH      = 32;

  typedef enum logic [1:0] {
    WB_REQ_MUL = 2'd0,
    WB_REQ_DIV = 2'd1,
    WB_REQ_CSR = 2'd2,
    WB_REQ_LSU = 2'd3
  } wb_req_idx_e;

  typedef struct packed {
    logic [WB_COMMIT_ID_WIDTH-1:0] commit_id;
    logic [WB_REG_ADDR_WIDTH-1:0]  rd_addr;
    logic [WB_DATA_WIDTH-1:0]      rd_data;
    logic                          rd_we;
  } wb_req_t;

  // Pointer position following a grant to idx, wrapping at n.
  function automatic int wb_rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_commit_arbiter_if.sv
// rtl/wb_commit_arbiter_if.sv - request and writeback/commit bundle of the commit arbiter
//
// Purpose: groups the per-unit request handshake, the hold control and the
//          regfile/hazard-unit outputs.
// Modports: slave  - the arbiter (consumes requests, drives writeback/commit)
//           master - the EX units / regfile side (drives requests, observes results)
interface wb_commit_arbiter_if
  import wb_commit_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = NUM_WB_REQ,
  parameter int COMMIT_ID_WIDTH = WB_COMMIT_ID_WIDTH,
  parameter int REG_ADDR_WIDTH  = WB_REG_ADDR_WIDTH,
  parameter int DATA_WIDTH      = WB_DATA_WIDTH,
  parameter int IDX_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ*COMMIT_ID_WIDTH-1:0] req_commit_id_i;
  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_rd_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0]      req_rd_data_i;
  logic [NUM_REQ-1:0]                 req_rd_we_i;
  logic                               hold_i;
  logic                               wb_we_o;
  logic [REG_ADDR_WIDTH-1:0]          wb_addr_o;
  logic [DATA_WIDTH-1:0]              wb_data_o;
  logic                               commit_valid_o;
  logic [COMMIT_ID_WIDTH-1:0]         commit_id_o;
  logic [IDX_WIDTH-1:0]               grant_idx_o;
  logic                               err_dup_id_o;

  modport slave (
    input  req_valid_i, req_commit_id_i, req_rd_addr_i, req_rd_data_i,
           req_rd_we_i, hold_i,
    output req_ready_o, wb_we_o, wb_addr_o, wb_data_o, commit_valid_o,
           commit_id_o, grant_idx_o, err_dup_id_o
  );

  modport master (
    output req_valid_i, req_commit_id_i, req_rd_addr_i, req_rd_data_i,
           req_rd_we_i, hold_i,
    input  req_ready_o, wb_we_o, wb_addr_o, wb_data_o, commit_valid_o,
           commit_id_o, grant_idx_o, err_dup_id_o
  );

endinterface

// File: rtl/wb_commit_arbiter_rr_arbiter.sv
// rtl/wb_commit_arbiter_rr_arbiter.sv - N-way round-robin grant from an external pointer
//
// Purpose: combinational round-robin pick; the first asserted request at or
//          after ptr_i (wrapping) wins. Shared with the FP writeback port.
// Ports:   req_i       - request vector
//          ptr_i       - search start index
//          en_i        - 0 suppresses every grant
//          gnt_o       - one-hot grant (all zero when nothing granted)
//          gnt_idx_o   - binary index of the grant
//          gnt_valid_o - a grant was made
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  int j;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (en_i && !gnt_valid_o && req_i[j]) begin
        gnt_valid_o = 1'b1;
        gnt_o[j]    = 1'b1;
        gnt_idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_commit_arbiter.sv
// rtl/wb_commit_arbiter.sv - round-robin arbiter for the integer writeback/commit port
//
// Purpose: picks one completing EX unit per cycle (MUL, DIV, CSR, LSU), registers
//          it and drives the regfile write plus the scoreboard commit pulse one
//          cycle later.
// Ports:   clk, rst_n - clock, asynchronous active-low reset
//          bus        - slave side of wb_commit_arbiter_if: per-unit
//                       valid/ready/commit_id/rd_addr/rd_data/rd_we, hold,
//                       wb_we/wb_addr/wb_data, commit_valid/commit_id,
//                       grant_idx (debug), err_dup_id (sticky)
module wb_commit_arbiter
  import wb_commit_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = NUM_WB_REQ,
  parameter int COMMIT_ID_WIDTH = WB_COMMIT_ID_WIDTH,
  parameter int REG_ADDR_WIDTH  = WB_REG_ADDR_WIDTH,
  parameter int DATA_WIDTH      = WB_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_commit_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wb_req_t req [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i].commit_id = bus.req_commit_id_i[i*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
      req[i].rd_addr   = bus.req_rd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      req[i].rd_data   = bus.req_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      req[i].rd_we     = bus.req_rd_we_i[i];
    end
  end

  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic                       commit_valid_q, commit_valid_d;
  logic                       wb_we_q, wb_we_d;
  logic [REG_ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]      wb_data_q, wb_data_d;
  logic [COMMIT_ID_WIDTH-1:0] commit_id_q, commit_id_d;
  logic [IW-1:0]              grant_idx_q, grant_idx_d;
  logic                       err_dup_q, err_dup_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_valid;
  logic               dup_id;
  wb_req_t            winner;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr_arbiter (
    .req_i       (bus.req_valid_i),
    .ptr_i       (rr_ptr_q),
    .en_i        (!bus.hold_i),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign bus.req_ready_o = gnt;
  assign winner          = req[gnt_idx];

  // Two live requests with the same ID means the scoreboard handed one slot
  // out twice; flag it, but keep arbitrating.
  always_comb begin
    dup_id = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = i + 1; k < NUM_REQ; k++) begin
        if (bus.req_valid_i[i] && bus.req_valid_i[k] &&
            req[i].commit_id == req[k].commit_id) begin
          dup_id = 1'b1;
        end
      end
    end
  end

  // Address/data/ID hold their last values on idle cycles; only the
  // strobes drop.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    wb_addr_d      = wb_addr_q;
    wb_data_d      = wb_data_q;
    commit_id_d    = commit_id_q;
    grant_idx_d    = grant_idx_q;
    commit_valid_d = gnt_valid;
    wb_we_d        = gnt_valid && winner.rd_we && (winner.rd_addr != '0);
    err_dup_d      = err_dup_q || dup_id;
    if (gnt_valid) begin
      rr_ptr_d    = IW'(wb_rr_next(int'(gnt_idx), NUM_REQ));
      wb_addr_d   = winner.rd_addr;
      wb_data_d   = winner.rd_data;
      commit_id_d = winner.commit_id;
      grant_idx_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      commit_valid_q <= 1'b0;
      wb_we_q        <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      commit_id_q    <= '0;
      grant_idx_q    <= '0;
      err_dup_q      <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      commit_valid_q <= commit_valid_d;
      wb_we_q        <= wb_we_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      commit_id_q    <= commit_id_d;
      grant_idx_q    <= grant_idx_d;
      err_dup_q      <= err_dup_d;
    end
  end

  assign bus.commit_valid_o = commit_valid_q;
  assign bus.wb_we_o        = wb_we_q;
  assign bus.wb_addr_o      = wb_addr_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.commit_id_o    = commit_id_q;
  assign bus.grant_idx_o    = grant_idx_q;
  assign bus.err_dup_id_o   = err_dup_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb/tb_wb_commit_arbiter.sv - directed-vector bench for wb_commit_arbiter
module tb_wb_commit_arbiter;
  import wb_commit_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  wb_commit_arbiter_if bus ();

  wb_commit_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] id, input logic [4:0] rd,
                         input logic [31:0] data, input logic we);
    bus.req_commit_id_i[idx*3 +: 3] = id;
    bus.req_rd_addr_i[idx*5 +: 5]   = rd;
    bus.req_rd_data_i[idx*32 +: 32] = data;
    bus.req_rd_we_i[idx]            = we;
  endtask

  task automatic chk_commit(input string tag, input logic [2:0] id, input logic we,
                            input logic [4:0] addr, input logic [31:0] data,
                            input logic [1:0] gidx);
    chk({tag, ".commit_valid"}, 64'(bus.commit_valid_o), 64'd1);
    chk({tag, ".commit_id"},    64'(bus.commit_id_o),    64'(id));
    chk({tag, ".wb_we"},        64'(bus.wb_we_o),        64'(we));
    chk({tag, ".wb_addr"},      64'(bus.wb_addr_o),      64'(addr));
    chk({tag, ".wb_data"},      64'(bus.wb_data_o),      64'(data));
    chk({tag, ".grant_idx"},    64'(bus.grant_idx_o),    64'(gidx));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid_i     = '0;
    bus.req_commit_id_i = '0;
    bus.req_rd_addr_i   = '0;
    bus.req_rd_data_i   = '0;
    bus.req_rd_we_i     = '0;
    bus.hold_i          = 1'b0;

    // reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst.commit_valid", 64'(bus.commit_valid_o), 64'd0);
    chk("rst.wb_we",        64'(bus.wb_we_o),        64'd0);
    chk("rst.wb_addr",      64'(bus.wb_addr_o),      64'd0);
    chk("rst.wb_data",      64'(bus.wb_data_o),      64'd0);
    chk("rst.commit_id",    64'(bus.commit_id_o),    64'd0);
    chk("rst.grant_idx",    64'(bus.grant_idx_o),    64'd0);
    chk("rst.err_dup",      64'(bus.err_dup_id_o),   64'd0);
    chk("rst.ready",        64'(bus.req_ready_o),    64'd0);
    step();
    rst_n = 1'b1;

    // MUL alone: id 3, x5, 0x1234
    set_req(int'(WB_REQ_MUL), 3'd3, 5'd5, 32'h1234, 1'b1);
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    chk("mul.ready", 64'(bus.req_ready_o), 64'b0001);
    step();
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk_commit("mul", 3'd3, 1'b1, 5'd5, 32'h1234, 2'd0);
    step();
    @(negedge clk);
    chk("idle.commit_valid", 64'(bus.commit_valid_o), 64'd0);
    chk("idle.wb_we",        64'(bus.wb_we_o),        64'd0);
    chk("idle.wb_addr_hold", 64'(bus.wb_addr_o),      64'd5);
    chk("idle.wb_data_hold", 64'(bus.wb_data_o),      64'h1234);
    chk("idle.id_hold",      64'(bus.commit_id_o),    64'd3);

    // LSU non-writing load (rr_ptr 1 -> LSU is only requester), pointer wraps to 0
    step();
    set_req(int'(WB_REQ_LSU), 3'd7, 5'd9, 32'hBEEF, 1'b0);
    bus.req_valid_i = 4'b1000;
    @(negedge clk);
    chk("lsu.ready", 64'(bus.req_ready_o), 64'b1000);
    step();
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk_commit("lsu_nowe", 3'd7, 1'b0, 5'd9, 32'hBEEF, 2'd3);

    // all four valid from rr_ptr 0: grants 0,1,2,3 with no bubble
    step();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 3'(i), 5'(i + 1), 32'h100 + 32'(i), 1'b1);
    end
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d.ready", k), 64'(bus.req_ready_o), 64'(4'b0001 << k));
      if (k > 0) begin
        chk($sformatf("rr%0d.commit_valid", k), 64'(bus.commit_valid_o), 64'd1);
        chk($sformatf("rr%0d.commit_id", k),    64'(bus.commit_id_o),    64'(k - 1));
      end
      step();
      bus.req_valid_i[k] = 1'b0;
    end
    @(negedge clk);
    chk_commit("rr3", 3'd3, 1'b1, 5'd4, 32'h103, 2'd3);

    // DIV writing x0: commit without regfile write
    step();
    set_req(int'(WB_REQ_DIV), 3'd6, 5'd0, 32'hDEAD, 1'b1);
    bus.req_valid_i = 4'b0010;
    @(negedge clk);
    chk("div.ready", 64'(bus.req_ready_o), 64'b0010);
    step();
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk_commit("div_x0", 3'd6, 1'b0, 5'd0, 32'hDEAD, 2'd1);

    // hold for 3 cycles with CSR valid
    step();
    bus.hold_i = 1'b1;
    set_req(int'(WB_REQ_CSR), 3'd5, 5'd7, 32'h55, 1'b1);
    bus.req_valid_i = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.ready", c),        64'(bus.req_ready_o),    64'd0);
      chk($sformatf("hold%0d.commit_valid", c), 64'(bus.commit_valid_o), 64'd0);
      step();
    end
    bus.hold_i = 1'b0;
    @(negedge clk);
    chk("csr.ready", 64'(bus.req_ready_o), 64'b0100);
    step();
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk_commit("csr", 3'd5, 1'b1, 5'd7, 32'h55, 2'd2);

    // hold raised right after a grant: the registered commit still appears
    step();
    set_req(int'(WB_REQ_LSU), 3'd1, 5'd4, 32'h77, 1'b1);
    bus.req_valid_i = 4'b1000;
    @(negedge clk);
    chk("lsu2.ready", 64'(bus.req_ready_o), 64'b1000);
    step();
    bus.hold_i      = 1'b1;
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk_commit("hold_late", 3'd1, 1'b1, 5'd4, 32'h77, 2'd3);
    step();
    bus.hold_i = 1'b0;

    // duplicate IDs on MUL and LSU, rr_ptr 0: MUL first, error sticks
    set_req(int'(WB_REQ_MUL), 3'd2, 5'd10, 32'hA, 1'b1);
    set_req(int'(WB_REQ_LSU), 3'd2, 5'd11, 32'hB, 1'b1);
    bus.req_valid_i = 4'b1001;
    @(negedge clk);
    chk("dup.ready0",  64'(bus.req_ready_o),  64'b0001);
    chk("dup.err_pre", 64'(bus.err_dup_id_o), 64'd0);
    step();
    bus.req_valid_i = 4'b1000;
    @(negedge clk);
    chk("dup.ready1", 64'(bus.req_ready_o),  64'b1000);
    chk("dup.err1",   64'(bus.err_dup_id_o), 64'd1);
    chk_commit("dup_mul", 3'd2, 1'b1, 5'd10, 32'hA, 2'd0);
    step();
    bus.req_valid_i = 4'b0000;
    @(negedge clk);
    chk("dup.err2", 64'(bus.err_dup_id_o), 64'd1);
    chk_commit("dup_lsu", 3'd2, 1'b1, 5'd11, 32'hB, 2'd3);
    step();
    @(negedge clk);
    chk("dup.err3", 64'(bus.err_dup_id_o), 64'd1);

    // grant then asynchronous reset before the next edge
    step();
    set_req(int'(WB_REQ_CSR), 3'd4, 5'd12, 32'hC, 1'b1);
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    chk("arst.ready", 64'(bus.req_ready_o), 64'b0100);
    step();
    chk("arst.pre_commit", 64'(bus.commit_valid_o), 64'd1);
    rst_n           = 1'b0;
    bus.req_valid_i = 4'b0000;
    #1;
    chk("arst.commit_valid", 64'(bus.commit_valid_o), 64'd0);
    chk("arst.wb_we",        64'(bus.wb_we_o),        64'd0);
    chk("arst.commit_id",    64'(bus.commit_id_o),    64'd0);
    chk("arst.wb_addr",      64'(bus.wb_addr_o),      64'd0);
    chk("arst.wb_data",      64'(bus.wb_data_o),      64'd0);
    chk("arst.grant_idx",    64'(bus.grant_idx_o),    64'd0);
    chk("arst.err_dup",      64'(bus.err_dup_id_o),   64'd0);
    step();
    step();
    rst_n = 1'b1;
    // rr_ptr back at 0: MUL beats LSU (a stale pointer of 3 would pick LSU)
    set_req(int'(WB_REQ_MUL), 3'd1, 5'd1, 32'h1, 1'b1);
    set_req(int'(WB_REQ_LSU), 3'd3, 5'd2, 32'h2, 1'b1);
    bus.req_valid_i = 4'b1001;
    @(negedge clk);
    chk("arst.ptr0_ready", 64'(bus.req_ready_o), 64'b0001);
    step();
    bus.req_valid_i = 4'b1000;
    @(negedge clk);
    chk_commit("post_rst", 3'd1, 1'b1, 5'd1, 32'h1, 2'd0);
    step();
    bus.req_valid_i = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
